// File: rtl/pll_csr_pkg.sv
// rtl/pll_csr_pkg.sv - register map, FSM states and register layouts for the PLL CSR block
package pll_csr_pkg;

    localparam logic [7:0] CTRL_OFF = 8'h00;
    localparam logic [7:0] DIV_OFF  = 8'h04;
    localparam logic [7:0] STAT_OFF = 8'h08;
    localparam logic [7:0] ID_OFF   = 8'h0C;
    localparam logic [7:0] MAP_END  = 8'h10;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA,
        ERR1,
        ERR2
    } csr_state_e;

    typedef struct packed {
        logic irq_en;
        logic bypass;
        logic en;
    } ctrl_t;

    typedef struct packed {
        logic [1:0] post_div;
        logic [5:0] ref_div;
        logic [7:0] fb_div;
    } div_t;

    // DIV may not be rewritten while the PLL is running
    function automatic logic is_bad_access(input logic [7:0] off, input logic [2:0] size,
                                           input logic wr, input logic pll_en);
        return (off >= MAP_END) || (off[1:0] != 2'b00) || (size > 3'b010) ||
               (wr && (off == ID_OFF)) || (wr && (off == DIV_OFF) && pll_en);
    endfunction

endpackage

// File: rtl/ahb_pll_csr_if.sv
// rtl/ahb_pll_csr_if.sv - AHB-Lite subordinate bus bundle for the PLL CSR block
interface ahb_pll_csr_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      HSEL;
    logic                      HWRITE;
    logic                      HMASTLOCK;
    logic                      HREADY;
    logic [1:0]                HTRANS;
    logic [2:0]                HBURST;
    logic [2:0]                HSIZE;
    logic [ADDR_WIDTH-1:0]     HADDR;
    logic [DATA_WIDTH-1:0]     HWDATA;
    logic [DATA_WIDTH/8-1:0]   HWSTRB;
    logic                      HREADYOUT;
    logic                      HRESP;
    logic [DATA_WIDTH-1:0]     HRDATA;

    modport master (
        output HSEL, HWRITE, HMASTLOCK, HREADY, HTRANS, HBURST, HSIZE, HADDR, HWDATA, HWSTRB,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HWRITE, HMASTLOCK, HREADY, HTRANS, HBURST, HSIZE, HADDR, HWDATA, HWSTRB,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchroniser for the PLL lock input with falling-edge detect
module pll_lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_lock,
    output logic o_lock_sync,
    output logic o_lock_fall
);
    logic r_meta;
    logic r_sync;
    logic r_sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta   <= 1'b0;
            r_sync   <= 1'b0;
            r_sync_d <= 1'b0;
        end else begin
            r_meta   <= i_lock;
            r_sync   <= r_meta;
            r_sync_d <= r_sync;
        end
    end

    assign o_lock_sync = r_sync;
    assign o_lock_fall = r_sync_d & ~r_sync;
endmodule

// File: rtl/ahb_pll_csr.sv
// rtl/ahb_pll_csr.sv - AHB-Lite PLL control/status registers; PLL_CSR_LOCK_IRQ_EN enables the lock-lost interrupt
module ahb_pll_csr
    import pll_csr_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          WAIT_STATES = 0,
    parameter logic [7:0]  FB_DIV_RST  = 8'd40,
    parameter logic [31:0] ID_VALUE    = 32'h504C_4C01
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_pll_csr_if.slave    bus,
    input  logic            pll_lock,
    output logic            pll_en,
    output logic            pll_bypass,
    output logic [7:0]      fb_div,
    output logic [5:0]      ref_div,
    output logic [1:0]      post_div,
    output logic            lock_irq
);
    localparam logic [1:0] WS_LAST = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    csr_state_e             r_state;
    csr_state_e             w_state_nxt;
    logic [1:0]             r_wait_cnt;
    logic [1:0]             w_wait_cnt_nxt;
    logic [7:0]             r_addr;
    logic                   r_write;
    logic [2:0]             r_size;
    logic                   r_err;
    logic                   w_start;

    ctrl_t                  r_ctrl;
    div_t                   r_div;
    logic                   r_lock_lost;
    logic                   w_lock_sync;
    logic                   w_lock_fall;

    logic                   w_accept;
    logic                   w_commit;
    logic                   w_en_eff;
    logic                   w_bad;
    logic [DATA_WIDTH-1:0]  w_rdata;

    pll_lock_sync u_lock_sync (
        .clk         (HCLK),
        .rst         (HRESET),
        .i_lock      (pll_lock),
        .o_lock_sync (w_lock_sync),
        .o_lock_fall (w_lock_fall)
    );

    assign w_accept = bus.HSEL & bus.HREADY & bus.HTRANS[1];
    assign w_commit = (r_state == DATA) & r_write;

    // A CTRL write completing this cycle decides whether a pipelined DIV write is legal
    assign w_en_eff = (w_commit && (r_addr == CTRL_OFF) && bus.HWSTRB[0]) ? bus.HWDATA[0] : r_ctrl.en;
    assign w_bad    = is_bad_access(bus.HADDR[7:0], bus.HSIZE, bus.HWRITE, w_en_eff);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state    <= IDLE;
            r_wait_cnt <= 2'd0;
            r_addr     <= 8'd0;
            r_write    <= 1'b0;
            r_size     <= 3'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_start) begin
                r_addr  <= bus.HADDR[7:0];
                r_write <= bus.HWRITE;
                r_size  <= bus.HSIZE;
                r_err   <= w_bad;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_start        = 1'b0;
        bus.HREADYOUT  = 1'b1;
        bus.HRESP      = 1'b0;
        bus.HRDATA     = '0;
        case (r_state)
            IDLE, DATA, ERR2: begin
                if (r_state == DATA && !r_write) begin
                    bus.HRDATA = w_rdata;
                end
                if (r_state == ERR2) begin
                    bus.HRESP = 1'b1;
                end
                if (w_accept) begin
                    w_start = 1'b1;
                    if (WAIT_STATES != 0) begin
                        w_state_nxt    = WAIT;
                        w_wait_cnt_nxt = WS_LAST;
                    end else begin
                        w_state_nxt = w_bad ? ERR1 : DATA;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                bus.HREADYOUT = 1'b0;
                if (r_wait_cnt == 2'd0) begin
                    w_state_nxt = r_err ? ERR1 : DATA;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt - 2'd1;
                end
            end
            ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
                w_state_nxt   = ERR2;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ctrl      <= '0;
            r_div       <= '{post_div: 2'd0, ref_div: 6'd1, fb_div: FB_DIV_RST};
            r_lock_lost <= 1'b0;
        end else begin
            if (w_commit && (r_addr == CTRL_OFF) && bus.HWSTRB[0]) begin
                r_ctrl.en     <= bus.HWDATA[0];
                r_ctrl.bypass <= bus.HWDATA[1];
`ifdef PLL_CSR_LOCK_IRQ_EN
                r_ctrl.irq_en <= bus.HWDATA[2];
`endif
            end
            if (w_commit && (r_addr == DIV_OFF)) begin
                if (bus.HWSTRB[0]) r_div.fb_div   <= bus.HWDATA[7:0];
                if (bus.HWSTRB[1]) r_div.ref_div  <= bus.HWDATA[13:8];
                if (bus.HWSTRB[2]) r_div.post_div <= bus.HWDATA[17:16];
            end
            // A new loss of lock outranks a simultaneous clear
            if (w_lock_fall && r_ctrl.en) begin
                r_lock_lost <= 1'b1;
            end else if (w_commit && (r_addr == STAT_OFF) && bus.HWSTRB[0] && bus.HWDATA[1]) begin
                r_lock_lost <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (r_addr)
            CTRL_OFF: w_rdata[2:0] = r_ctrl;
            DIV_OFF: begin
                w_rdata[7:0]   = r_div.fb_div;
                w_rdata[13:8]  = r_div.ref_div;
                w_rdata[17:16] = r_div.post_div;
            end
            STAT_OFF: w_rdata[1:0] = {r_lock_lost, w_lock_sync};
            ID_OFF:   w_rdata = ID_VALUE;
            default:  w_rdata = '0;
        endcase
    end

`ifdef PLL_CSR_LOCK_IRQ_EN
    logic r_lock_irq;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_lock_irq <= 1'b0;
        end else begin
            r_lock_irq <= r_lock_lost & r_ctrl.irq_en;
        end
    end

    assign lock_irq = r_lock_irq;
`else
    assign lock_irq = 1'b0;
`endif

    assign pll_en     = r_ctrl.en;
    assign pll_bypass = r_ctrl.bypass;
    assign fb_div     = r_div.fb_div;
    assign ref_div    = r_div.ref_div;
    assign post_div   = r_div.post_div;

    wire w_unused_ok = &{1'b0, bus.HBURST, bus.HMASTLOCK, bus.HTRANS[0], bus.HADDR[ADDR_WIDTH-1:8],
                         bus.HWDATA[DATA_WIDTH-1:18], bus.HWDATA[15:14], bus.HWSTRB[DATA_WIDTH/8-1:3],
                         r_size};

endmodule

// File: tb/tb_ahb_pll_csr.sv
// tb/tb_ahb_pll_csr.sv - randomized self-checking bench for ahb_pll_csr (zero and two wait-state instances)
`timescale 1ns/1ps
module tb_ahb_pll_csr;
    localparam logic [31:0] ID_VAL = 32'h504C_4C01;

    typedef struct {
        bit        wr;
        bit [7:0]  addr;
        bit [31:0] wdata;
        bit [3:0]  strb;
        bit [2:0]  size;
    } tr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        hsel, hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata;
    logic [3:0]  hstrb;
    logic        pll_lock;

    logic        en0, byp0, irq0, en2, byp2, irq2;
    logic [7:0]  fb0, fb2;
    logic [5:0]  ref0, ref2;
    logic [1:0]  post0, post2;

    ahb_pll_csr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    ahb_pll_csr_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus2 ();

    assign bus0.HSEL = hsel & ~sel;    assign bus2.HSEL = hsel & sel;
    assign bus0.HWRITE = hwrite;       assign bus2.HWRITE = hwrite;
    assign bus0.HMASTLOCK = 1'b0;      assign bus2.HMASTLOCK = 1'b0;
    assign bus0.HREADY = bus0.HREADYOUT; assign bus2.HREADY = bus2.HREADYOUT;
    assign bus0.HTRANS = htrans;       assign bus2.HTRANS = htrans;
    assign bus0.HBURST = 3'b000;       assign bus2.HBURST = 3'b000;
    assign bus0.HSIZE = hsize;         assign bus2.HSIZE = hsize;
    assign bus0.HADDR = haddr;         assign bus2.HADDR = haddr;
    assign bus0.HWDATA = hwdata;       assign bus2.HWDATA = hwdata;
    assign bus0.HWSTRB = hstrb;        assign bus2.HWSTRB = hstrb;

    wire        w_rdy   = sel ? bus2.HREADYOUT : bus0.HREADYOUT;
    wire        w_resp  = sel ? bus2.HRESP : bus0.HRESP;
    wire [31:0] w_rdata = sel ? bus2.HRDATA : bus0.HRDATA;

    ahb_pll_csr #(.WAIT_STATES(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .bus(bus0), .pll_lock(pll_lock),
        .pll_en(en0), .pll_bypass(byp0), .fb_div(fb0), .ref_div(ref0), .post_div(post0), .lock_irq(irq0)
    );

    ahb_pll_csr #(.WAIT_STATES(2)) u_dut2 (
        .HCLK(clk), .HRESET(rst), .bus(bus2), .pll_lock(pll_lock),
        .pll_en(en2), .pll_bypass(byp2), .fb_div(fb2), .ref_div(ref2), .post_div(post2), .lock_irq(irq2)
    );

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference register file, one entry per instance
    bit       m_en[2], m_byp[2], m_irqen[2], m_lost[2];
    bit [7:0] m_fb[2];
    bit [5:0] m_ref[2];
    bit [1:0] m_post[2];
    bit       m_lock;

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_en[d] = 0; m_byp[d] = 0; m_irqen[d] = 0; m_lost[d] = 0;
            m_fb[d] = 8'd40; m_ref[d] = 6'd1; m_post[d] = 2'd0;
        end
    endtask

    task automatic model_xfer(input int d, input tr_t t, output logic [31:0] rd, output bit err);
        bit [7:0] a;
        a = t.addr;
        err = (a >= 8'h10) || (a % 4 != 0) || (t.size > 3'd2) || (t.wr && a == 8'h0C) ||
              (t.wr && a == 8'h04 && m_en[d]);
        rd = 32'h0;
        if (err) return;
        if (!t.wr) begin
            case (a)
                8'h00: rd = 32'(m_irqen[d]) * 4 + 32'(m_byp[d]) * 2 + 32'(m_en[d]);
                8'h04: rd = 32'(m_post[d]) * 65536 + 32'(m_ref[d]) * 256 + 32'(m_fb[d]);
                8'h08: rd = 32'(m_lost[d]) * 2 + 32'(m_lock);
                default: rd = ID_VAL;
            endcase
        end else begin
            if (a == 8'h00 && t.strb[0]) begin
                m_en[d]  = t.wdata[0];
                m_byp[d] = t.wdata[1];
`ifdef PLL_CSR_LOCK_IRQ_EN
                m_irqen[d] = t.wdata[2];
`endif
            end
            if (a == 8'h04) begin
                if (t.strb[0]) m_fb[d]   = t.wdata[7:0];
                if (t.strb[1]) m_ref[d]  = t.wdata[13:8];
                if (t.strb[2]) m_post[d] = t.wdata[17:16];
            end
            if (a == 8'h08 && t.strb[0] && t.wdata[1]) m_lost[d] = 0;
        end
    endtask

    tr_t         q[$];
    logic [31:0] res_rdata[8];
    logic        res_resp[8];
    int          res_waits[8];

    function automatic tr_t mk(input bit wr, input bit [7:0] addr, input bit [31:0] wdata,
                               input bit [3:0] strb, input bit [2:0] size);
        tr_t t;
        t.wr = wr; t.addr = addr; t.wdata = wdata; t.strb = strb; t.size = size;
        return t;
    endfunction

    function automatic tr_t rand_tr();
        tr_t t;
        int  k;
        k = $urandom_range(0, 11);
        t.addr = (k < 3) ? 8'h00 : (k < 6) ? 8'h04 : (k < 8) ? 8'h08 : (k == 8) ? 8'h0C :
                 (k == 9) ? 8'h10 : (k == 10) ? 8'h20 : 8'(($urandom_range(0, 3) * 4) + $urandom_range(1, 3));
        t.wr    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.strb  = 4'($urandom_range(0, 15));
        t.size  = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'd2;
        return t;
    endfunction

    task automatic drive_addr(input int ap);
        if (ap >= 0) begin
            hsel = 1'b1; htrans = 2'b10; hwrite = q[ap].wr;
            haddr = {24'h0, q[ap].addr}; hsize = q[ap].size;
        end else begin
            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        end
    endtask

    // Issues everything in q back to back; entered and left just after a rising edge
    task automatic run_q();
        int   n, ap, cur, waits, guard;
        logic rdy;
        n = q.size(); ap = 0; cur = -1; waits = 0; guard = 0;
        drive_addr(ap);
        forever begin
            @(negedge clk);
            rdy = w_rdy;
            if (cur >= 0) begin
                if (rdy) begin
                    res_rdata[cur] = w_rdata; res_resp[cur] = w_resp; res_waits[cur] = waits;
                end else begin
                    waits++;
                end
            end
            @(posedge clk); #1;
            if (rdy) begin
                cur = ap; waits = 0;
                if (ap >= 0) ap = (ap + 1 < n) ? ap + 1 : -1;
                if (cur >= 0) begin
                    hwdata = q[cur].wdata; hstrb = q[cur].strb;
                end else begin
                    hwdata = 32'h0; hstrb = 4'h0;
                end
                drive_addr(ap);
                if (cur < 0 && ap < 0) break;
            end
            guard++;
            if (guard > 60) begin
                check("run_q_cycle_budget", 32'(guard), 32'd60);
                hsel = 1'b0; htrans = 2'b00;
                break;
            end
        end
    endtask

    task automatic check_pins(input int d, input string tag);
        logic exp_irq;
        @(posedge clk); #1;
`ifdef PLL_CSR_LOCK_IRQ_EN
        exp_irq = m_lost[d] & m_irqen[d];
`else
        exp_irq = 1'b0;
`endif
        check({tag, ".pll_en"},   32'(d != 0 ? en2 : en0),     32'(m_en[d]));
        check({tag, ".bypass"},   32'(d != 0 ? byp2 : byp0),   32'(m_byp[d]));
        check({tag, ".fb_div"},   32'(d != 0 ? fb2 : fb0),     32'(m_fb[d]));
        check({tag, ".ref_div"},  32'(d != 0 ? ref2 : ref0),   32'(m_ref[d]));
        check({tag, ".post_div"}, 32'(d != 0 ? post2 : post0), 32'(m_post[d]));
        check({tag, ".lock_irq"}, 32'(d != 0 ? irq2 : irq0),   32'(exp_irq));
    endtask

    task automatic run_and_check(input int d, input string tag);
        logic [31:0] erd;
        bit          eerr;
        sel = (d != 0);
        run_q();
        for (int i = 0; i < q.size(); i++) begin
            model_xfer(d, q[i], erd, eerr);
            check($sformatf("%s[%0d].rdata", tag, i), res_rdata[i], erd);
            check($sformatf("%s[%0d].resp", tag, i), 32'(res_resp[i]), 32'(eerr));
            check($sformatf("%s[%0d].waits", tag, i), 32'(res_waits[i]), 32'((d != 0 ? 2 : 0) + int'(eerr)));
        end
        check_pins(d, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic exp_irq;
        sel = 1'b0; hsel = 1'b0; hwrite = 1'b0; htrans = 2'b00; hsize = 3'd2;
        haddr = 32'h0; hwdata = 32'h0; hstrb = 4'h0; pll_lock = 1'b1; rst = 1'b1;
        model_reset(); m_lock = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst.hreadyout", 32'(bus0.HREADYOUT), 32'd1);
        check("rst.hresp",     32'(bus0.HRESP), 32'd0);
        check("rst.hrdata",    bus0.HRDATA, 32'h0);
        check_pins(0, "rst");

        hsel = 1'b1; htrans = 2'b01;
        @(negedge clk);
        check("busy.hreadyout", 32'(bus0.HREADYOUT), 32'd1);
        check("busy.hresp",     32'(bus0.HRESP), 32'd0);
        @(posedge clk); #1 hsel = 1'b0; htrans = 2'b00;

        q = '{mk(0, 8'h04, 0, 0, 2), mk(0, 8'h0C, 0, 0, 2)};
        run_and_check(0, "rd_rst");
        check("div_rst_value", res_rdata[0], 32'h0000_0128);
        check("id_value",      res_rdata[1], ID_VAL);

        q = '{mk(1, 8'h04, 32'h0002_0A32, 4'b0001, 2), mk(0, 8'h04, 0, 0, 2)};
        run_and_check(0, "div_strb");
        check("div_strb_readback", res_rdata[1], 32'h0000_0132);

        q = '{mk(1, 8'h00, 32'h1, 4'hF, 2), mk(1, 8'h04, 32'h0003_3F11, 4'hF, 2), mk(0, 8'h04, 0, 0, 2)};
        run_and_check(0, "div_locked");
        check("div_locked.resp", 32'(res_resp[1]), 32'd1);
        check("div_locked.keep", res_rdata[2], 32'h0000_0132);

        q = '{mk(0, 8'h20, 0, 0, 2), mk(0, 8'h00, 0, 0, 3)};
        run_and_check(0, "bad_acc");

        q = '{mk(0, 8'h00, 0, 0, 2)};
        run_and_check(1, "ws_rd");
        check("ws_rd.waits_const", 32'(res_waits[0]), 32'd2);

        q = '{mk(1, 8'h00, 32'h2, 4'h1, 2), mk(0, 8'h00, 0, 0, 2)};
        run_and_check(1, "ws_b2b");
        check("ws_b2b.readback", res_rdata[1], 32'h2);

        sel = 1'b0;
        q = '{mk(1, 8'h00, 32'h5, 4'h1, 2)};
        run_and_check(0, "irq_en");
        pll_lock = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("lock_irq_early", 32'(irq0), 32'd0);
        repeat (2) @(posedge clk);
        for (int d = 0; d < 2; d++) if (m_en[d]) m_lost[d] = 1;
        m_lock = 0;
`ifdef PLL_CSR_LOCK_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        #1 check("lock_irq_set", 32'(irq0), 32'(exp_irq));
        q = '{mk(0, 8'h08, 0, 0, 2)};
        run_and_check(0, "stat_lost");
        check("stat_lost.value", res_rdata[0], 32'h2);
        q = '{mk(1, 8'h08, 32'h2, 4'h1, 2), mk(0, 8'h08, 0, 0, 2)};
        run_and_check(0, "stat_w1c");
        check("stat_w1c.value", res_rdata[1], 32'h0);
        pll_lock = 1'b1;
        repeat (4) @(posedge clk);
        #1 m_lock = 1;

        for (int d = 0; d < 2; d++) begin
            for (int b = 0; b < 15; b++) begin
                int n;
                q.delete();
                n = $urandom_range(1, 3);
                for (int i = 0; i < n; i++) q.push_back(rand_tr());
                run_and_check(d, $sformatf("rnd%0d_%0d", d, b));
            end
        end

        sel = 1'b1;
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2;
        @(posedge clk); #1;
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h3; hstrb = 4'hF;
        @(negedge clk);
        check("rst_mid.wait_low", 32'(bus2.HREADYOUT), 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_mid.hreadyout", 32'(bus2.HREADYOUT), 32'd1);
        check("rst_mid.bypass",    32'(byp2), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        q = '{mk(0, 8'h00, 0, 0, 2)};
        run_and_check(1, "rst_mid_rd");
        check("rst_mid.ctrl", res_rdata[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
